// File: rtl/io_input_frontend_pkg.sv
// Shared types and helpers for the board input front end.
// The debounce state type and counter sizing live here so every block agrees on them.
package io_input_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounce_state_t;

  // The counter must hold DEBOUNCE_CYCLES-1 and never needs to wrap.
  function automatic int debounce_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_input_frontend_if.sv
// Pin-side and datapath-side signals of the input front end.
// master drives the raw pins and reads the port strobes; slave is the front end itself.
interface io_input_frontend_if #(
  parameter int WIDTH        = 32,
  parameter int NUM_BUTTONS  = 2,
  parameter int NUM_SWITCHES = 10
);

  logic [NUM_BUTTONS-1:0]  buttons_raw;
  logic [NUM_SWITCHES-1:0] switches_raw;
  logic [WIDTH-1:0]        inport_data;
  logic [NUM_BUTTONS-1:0]  inport_en;
  logic [NUM_BUTTONS-1:0]  button_level;

  modport master (
    output buttons_raw,
    output switches_raw,
    input  inport_data,
    input  inport_en,
    input  button_level
  );

  modport slave (
    input  buttons_raw,
    input  switches_raw,
    output inport_data,
    output inport_en,
    output button_level
  );

endinterface

// File: rtl/io_input_frontend_button_debouncer.sv
// One push-button: synchronizer chain, polarity fix, debounce FSM with counter.
// pulse is the registered one-cycle press strobe; accept is its combinational precursor.
module button_debouncer
  import io_input_frontend_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic accept
);

  localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_IDLE = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_reg;
  debounce_state_t        state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   synced;
  logic                   cnt_done;

  // After this point a pressed button always reads as 1.
  assign synced   = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign cnt_done = (cnt_reg == CNT_LAST);
  assign accept   = (state_reg == PRESS_WAIT) && synced && cnt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= {SYNC_STAGES{RAW_IDLE}};
      state_reg <= IDLE;
      cnt_reg   <= '0;
      level     <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      pulse    <= accept;
      unique case (state_reg)
        IDLE: begin
          if (synced) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!synced) begin
            state_reg <= IDLE;
          end else if (cnt_done) begin
            state_reg <= PRESSED;
            level     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!synced) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed keeps the level and produces no new strobe.
          if (synced) begin
            state_reg <= PRESSED;
          end else if (cnt_done) begin
            state_reg <= IDLE;
            level     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_input_frontend.sv
// Board input front end: debounced button strobes plus a switch snapshot
// captured on the same edge, ready to load the CPU input ports.
module io_input_frontend
  import io_input_frontend_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int NUM_BUTTONS       = 2,
  parameter int NUM_SWITCHES      = 10,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  io_input_frontend_if.slave  bus
);

  logic [SYNC_STAGES-1:0][NUM_SWITCHES-1:0] sw_sync_reg;
  logic [WIDTH-1:0]                         inport_data_reg;
  logic [NUM_BUTTONS-1:0]                   level_vec;
  logic [NUM_BUTTONS-1:0]                   pulse_vec;
  logic [NUM_BUTTONS-1:0]                   accept_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BUTTON_ACTIVE_LOW)
      ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.buttons_raw[gi]),
        .level  (level_vec[gi]),
        .pulse  (pulse_vec[gi]),
        .accept (accept_vec[gi])
      );
    end
  endgenerate

  // The snapshot uses accept so data lands on the same edge the strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync_reg     <= '0;
      inport_data_reg <= '0;
    end else begin
      sw_sync_reg[0] <= bus.switches_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_reg[i] <= sw_sync_reg[i-1];
      end
      if (|accept_vec) begin
        inport_data_reg <= WIDTH'(sw_sync_reg[SYNC_STAGES-1]);
      end
    end
  end

  assign bus.inport_data  = inport_data_reg;
  assign bus.inport_en    = pulse_vec;
  assign bus.button_level = level_vec;

endmodule

// File: tb/tb_io_input_frontend.sv
// Scoreboard bench for io_input_frontend: a run-length debounce model predicts
// strobes and snapshots; a negedge monitor compares whatever the DUT presents.
module tb_io_input_frontend;

  localparam int WIDTH = 32;
  localparam int NB    = 2;
  localparam int NS    = 10;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int LAT   = SYNC + DEB + 1;

  typedef struct packed {
    logic [NB-1:0]    en;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_input_frontend_if #(.WIDTH(WIDTH), .NUM_BUTTONS(NB), .NUM_SWITCHES(NS)) bus ();

  io_input_frontend #(
    .WIDTH(WIDTH), .NUM_BUTTONS(NB), .NUM_SWITCHES(NS),
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a level is accepted once the synchronized input has
  // disagreed with it for DEB+1 consecutive clock samples.
  exp_t             exp_q[$];
  logic [NB-1:0]    btn_hist[$];
  logic [NS-1:0]    sw_hist[$];
  int               run[NB];
  logic [NB-1:0]    acc;
  logic [WIDTH-1:0] model_data;
  logic [NB-1:0]    m_pressed;
  logic [NS-1:0]    m_sw;
  logic [NB-1:0]    m_strobe;

  always @(posedge clk) begin
    if (rst) begin
      btn_hist.delete();
      sw_hist.delete();
      for (int k = 0; k < SYNC; k++) begin
        btn_hist.push_back({NB{1'b1}});
        sw_hist.push_back('0);
      end
      for (int k = 0; k < NB; k++) run[k] = 0;
      acc        = '0;
      model_data = '0;
    end else begin
      m_pressed = ~btn_hist[0];
      m_sw      = sw_hist[0];
      m_strobe  = '0;
      for (int k = 0; k < NB; k++) begin
        if (m_pressed[k] != acc[k]) begin
          run[k]++;
          if (run[k] == DEB + 1) begin
            acc[k] = m_pressed[k];
            run[k] = 0;
            if (acc[k]) m_strobe[k] = 1'b1;
          end
        end else begin
          run[k] = 0;
        end
      end
      if (m_strobe != '0) begin
        model_data = WIDTH'(m_sw);
        exp_q.push_back('{en: m_strobe, data: model_data});
      end
      void'(btn_hist.pop_front());
      void'(sw_hist.pop_front());
      btn_hist.push_back(bus.buttons_raw);
      sw_hist.push_back(bus.switches_raw);
    end
  end

  // Monitor: an expected entry must coincide exactly with a DUT strobe.
  exp_t got;
  always @(negedge clk) begin
    if (bus.inport_en != '0) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(bus.inport_en), 64'(0));
      end else begin
        got = exp_q.pop_front();
        check("strobe_en", 64'(bus.inport_en), 64'(got.en));
        check("strobe_data", 64'(bus.inport_data), 64'(got.data));
      end
    end else if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check("missed_strobe", 64'(bus.inport_en), 64'(got.en));
    end
    check("button_level", 64'(bus.button_level), 64'(acc));
    check("held_data", 64'(bus.inport_data), 64'(model_data));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from now until a strobe appears; -1 if none within the bound.
  task automatic wait_strobe(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.inport_en != '0) begin
        lat = e;
        break;
      end
    end
  endtask

  int lat;
  int base;

  initial begin
    bus.buttons_raw  = 2'b11;
    bus.switches_raw = '0;
    rst = 1'b1;
    cycles(3);
    check("rst_data", 64'(bus.inport_data), 64'(0));
    check("rst_en", 64'(bus.inport_en), 64'(0));
    check("rst_level", 64'(bus.button_level), 64'(0));
    rst = 1'b0;
    cycles(4);

    // Clean press on button 0
    bus.switches_raw = 10'h2A5;
    bus.buttons_raw  = 2'b10;
    wait_strobe(lat);
    check("press0_latency", 64'(lat), 64'(LAT));
    check("press0_en", 64'(bus.inport_en), 64'(2'b01));
    check("press0_data", 64'(bus.inport_data), 64'h2A5);
    check("press0_level", 64'(bus.button_level[0]), 64'(1));
    @(posedge clk); #1;
    check("press0_one_cycle", 64'(bus.inport_en), 64'(0));
    cycles(10);
    bus.buttons_raw = 2'b11;
    cycles(12);

    // Bouncy press: low 2, high 1, then low and stable
    base = strobe_cnt;
    bus.buttons_raw = 2'b10; cycles(2);
    bus.buttons_raw = 2'b11; cycles(1);
    bus.buttons_raw = 2'b10;
    wait_strobe(lat);
    check("bounce_latency", 64'(lat), 64'(LAT));
    cycles(20);
    check("bounce_one_strobe", 64'(strobe_cnt - base), 64'(1));
    bus.buttons_raw = 2'b11;
    cycles(12);

    // Long hold on button 1, short release, long release
    base = strobe_cnt;
    bus.buttons_raw = 2'b01; cycles(100);
    check("hold1_one_strobe", 64'(strobe_cnt - base), 64'(1));
    bus.buttons_raw = 2'b11; cycles(2);
    bus.buttons_raw = 2'b01; cycles(20);
    check("short_release_no_strobe", 64'(strobe_cnt - base), 64'(1));
    bus.buttons_raw = 2'b11; cycles(10);
    bus.buttons_raw = 2'b01; cycles(20);
    check("long_release_strobe", 64'(strobe_cnt - base), 64'(2));
    bus.buttons_raw = 2'b11;
    cycles(12);

    // Simultaneous press sharing one snapshot
    bus.switches_raw = 10'h3FF;
    bus.buttons_raw  = 2'b00;
    wait_strobe(lat);
    check("both_latency", 64'(lat), 64'(LAT));
    check("both_en", 64'(bus.inport_en), 64'(2'b11));
    check("both_data", 64'(bus.inport_data), 64'h3FF);
    @(posedge clk); #1;
    check("both_one_cycle", 64'(bus.inport_en), 64'(0));
    cycles(5);
    bus.buttons_raw = 2'b11;
    cycles(12);

    // Reset in the middle of a press
    base = strobe_cnt;
    bus.switches_raw = 10'h155;
    bus.buttons_raw  = 2'b10;
    cycles(4);
    rst = 1'b1;
    cycles(2);
    check("rst_mid_no_strobe", 64'(strobe_cnt - base), 64'(0));
    check("rst_mid_data", 64'(bus.inport_data), 64'(0));
    rst = 1'b0;
    wait_strobe(lat);
    check("rst_mid_latency", 64'(lat), 64'(LAT));
    check("rst_mid_data_after", 64'(bus.inport_data), 64'h155);
    cycles(5);
    bus.buttons_raw = 2'b11;
    cycles(12);

    // Randomized segments, including switch churn and occasional resets
    for (int s = 0; s < 300; s++) begin
      bus.buttons_raw  = NB'($urandom);
      bus.switches_raw = NS'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      cycles($urandom_range(1, 9));
    end

    bus.buttons_raw = 2'b11;
    cycles(20);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
